serial_subtractor: RTL and testbench

//   Bit-serial unsigned subtractor computing A - B, LSB first, one bit per clock.
//   It is the inverse-direction counterpart to the lab's combinational ripple adders.

---
 rtl/serial_arith_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module   : serial_arith_pkg
// Brief    : Shared FSM encoding and default width for the bit-serial arithmetic blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

  localparam int SERIAL_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Brief    : One-bit full subtractor computing a - b - bin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned A - B, LSB first, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bw;
  logic             r_borrow;
  logic             w_d;
  logic             w_bout;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bw),
    .diff (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_state == ST_RUN) && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A new operation can be launched from IDLE or directly from the DONE cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bw     <= 1'b0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a_in;
      r_b    <= b_in;
      r_diff <= '0;
      r_cnt  <= '0;
      r_bw   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      // Difference bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_a    <= {1'b0, r_a[WIDTH-1:1]};
      r_b    <= {1'b0, r_b[WIDTH-1:1]};
      r_bw   <= w_bout;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_borrow <= w_bout;
      end
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  typedef struct {
    int diff;
    int bw;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst4_n = 1'b0;
  logic       rst8_n = 1'b0;
  logic       start4 = 1'b0;
  logic       start8 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [3:0] diff4;
  logic [7:0] diff8;
  logic       borrow4, borrow8, busy4, busy8, done4, done8;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q8[$];

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .a_in(a4), .b_in(b4),
    .diff(diff4), .borrow_out(borrow4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .a_in(a8), .b_in(b8),
    .diff(diff8), .borrow_out(borrow8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned difference modulo 2^w, borrow when a < b.
  function automatic exp_t model(input int a, input int b, input int w, input int acc);
    exp_t e;
    e.diff = (a - b) & ((1 << w) - 1);
    e.bw   = (a < b) ? 1 : 0;
    e.cyc  = acc + w;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst4_n) begin
      if (done4 === 1'b1) begin
        if (q4.size() == 0) begin
          chk("done4_unexpected", 1, 0);
        end else begin
          e = q4.pop_front();
          chk("diff4", int'(diff4), e.diff);
          chk("borrow4", int'(borrow4), e.bw);
          chk("latency4", cyc, e.cyc);
        end
      end else if (q4.size() > 0 && cyc > q4[0].cyc) begin
        chk("done4_timeout", 0, 1);
        void'(q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst8_n) begin
      if (done8 === 1'b1) begin
        if (q8.size() == 0) begin
          chk("done8_unexpected", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("diff8", int'(diff8), e.diff);
          chk("borrow8", int'(borrow8), e.bw);
          chk("latency8", cyc, e.cyc);
        end
      end else if (q8.size() > 0 && cyc > q8[0].cyc) begin
        chk("done8_timeout", 0, 1);
        void'(q8.pop_front());
      end
    end
  end

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input bit hold, input bit chk_busy);
    int guard = 0;
    while (busy4 !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    start4 = 1'b1;
    a4 = a;
    b4 = b;
    @(posedge clk);
    #1;
    q4.push_back(model(int'(a), int'(b), 4, cyc));
    if (!hold) start4 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    if (chk_busy) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("busy4_run", int'(busy4), 1);
      end
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    while (busy8 !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    @(posedge clk);
    #1;
    q8.push_back(model(int'(a), int'(b), 8, cyc));
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    #2;
    chk("rst_diff4", int'(diff4), 0);
    chk("rst_borrow4", int'(borrow4), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_done4", int'(done4), 0);
    chk("rst_diff8", int'(diff8), 0);
    chk("rst_busy8", int'(busy8), 0);
    @(negedge clk);
    rst4_n = 1'b1;
    rst8_n = 1'b1;
    @(negedge clk);

    issue4(4'd5, 4'd3, 1'b0, 1'b1);
    issue4(4'd3, 4'd5, 1'b0, 1'b1);
    issue4(4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Start pulsed mid-operation must be ignored.
    issue4(4'd15, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    start4 = 1'b1;
    a4 = 4'd0;
    b4 = 4'd0;
    @(negedge clk);
    start4 = 1'b0;
    chk("busy4_ignore", int'(busy4), 1);
    @(negedge clk);
    chk("busy4_ignore2", int'(busy4), 1);
    repeat (4) @(negedge clk);

    // Asynchronous reset two cycles into RUN.
    issue4(4'd9, 4'd2, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("arst_busy4", int'(busy4), 0);
    chk("arst_done4", int'(done4), 0);
    chk("arst_diff4", int'(diff4), 0);
    chk("arst_borrow4", int'(borrow4), 0);
    q4.delete();
    @(negedge clk);
    rst4_n = 1'b1;
    repeat (8) @(negedge clk);

    // Start held high: back-to-back results every WIDTH+1 cycles.
    for (int i = 0; i < 4; i++) issue4(4'd9, 4'd4, 1'b1, 1'b0);
    start4 = 1'b0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      issue4(4'($urandom), 4'($urandom), ($urandom_range(0, 1) == 1), 1'b0);
      start4 = ($urandom_range(0, 2) == 0) ? start4 : 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        start4 = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end
    start4 = 1'b0;

    issue8(8'h00, 8'h01);
    issue8(8'hFF, 8'hFF);
    issue8(8'h80, 8'h7F);
    for (int i = 0; i < 8; i++) issue8(8'($urandom), 8'($urandom));

    guard = 0;
    while ((q4.size() != 0 || q8.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (12) @(negedge clk);
    if (q4.size() != 0 || q8.size() != 0) chk("drain_queues", q4.size() + q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
